// File: rtl/cache_control_4way.sv
// Control FSM for a 4-way set-associative cache with 3-bit tree pseudo-LRU.
// Define CACHE_PERF_CNT_EN to build the hit/miss/write-back performance counters.
module cache_control_4way (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_resp,
  input  logic [3:0]  hit,
  input  logic        dirty_victim,
  input  logic [2:0]  lru_in,
  output logic [2:0]  lru_out,
  output logic        load_lru,
  output logic        read_arrays,
  output logic [3:0]  load_valid,
  output logic [3:0]  load_tag,
  output logic [3:0]  load_dirty,
  output logic        valid_in,
  output logic        dirty_in,
  output logic        update,
  output logic        write_back,
  output logic        write_data,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp,
  output logic [31:0] cnt_hit,
  output logic [31:0] cnt_miss,
  output logic [31:0] cnt_wb
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_TAG_CHECK  = 3'd1;
  localparam logic [2:0] ST_WRITE_BACK = 3'd2;
  localparam logic [2:0] ST_ALLOCATE   = 3'd3;
  localparam logic [2:0] ST_REFETCH    = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       req_s;
  logic [1:0] hit_way_s;
  logic [1:0] victim_way_s;

  // Multiple hit bits resolve to the lowest-numbered way.
  function automatic logic [1:0] first_hit(input logic [3:0] h);
    logic [1:0] w;
    w = 2'd0;
    if (h[0])      w = 2'd0;
    else if (h[1]) w = 2'd1;
    else if (h[2]) w = 2'd2;
    else if (h[3]) w = 2'd3;
    else           w = 2'd0;
    return w;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] lru);
    logic [1:0] w;
    if (lru[2]) w = lru[0] ? 2'd3 : 2'd2;
    else        w = lru[1] ? 2'd1 : 2'd0;
    return w;
  endfunction

  // Point the tree away from the accessed way, keeping the untouched subtree bit.
  function automatic logic [2:0] plru_touch(input logic [1:0] w, input logic [2:0] lru);
    logic [2:0] n;
    case (w)
      2'd0:    n = {1'b1, 1'b1, lru[0]};
      2'd1:    n = {1'b1, 1'b0, lru[0]};
      2'd2:    n = {1'b0, lru[1], 1'b1};
      2'd3:    n = {1'b0, lru[1], 1'b0};
      default: n = lru;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] way_onehot(input logic [1:0] w);
    return 4'b0001 << w;
  endfunction

  assign req_s        = mem_read | mem_write;
  assign hit_way_s    = first_hit(hit);
  assign victim_way_s = plru_victim(lru_in);

  // Next-state and Mealy output decode; reset forces every output low.
  always_comb begin
    state_d     = state_q;
    mem_resp    = 1'b0;
    lru_out     = 3'b000;
    load_lru    = 1'b0;
    read_arrays = 1'b0;
    load_valid  = 4'b0000;
    load_tag    = 4'b0000;
    load_dirty  = 4'b0000;
    valid_in    = 1'b0;
    dirty_in    = 1'b0;
    update      = 1'b0;
    write_back  = 1'b0;
    write_data  = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            read_arrays = 1'b1;
            state_d     = ST_TAG_CHECK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_TAG_CHECK: begin
          // A request abandoned during a miss lands here without a requester.
          if (!req_s) begin
            state_d = ST_IDLE;
          end else if (hit != 4'b0000) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_out  = plru_touch(hit_way_s, lru_in);
            if (mem_write) begin
              write_data = 1'b1;
              load_dirty = way_onehot(hit_way_s);
              dirty_in   = 1'b1;
            end else begin
              write_data = 1'b0;
            end
            state_d = ST_IDLE;
          end else if (dirty_victim) begin
            state_d = ST_WRITE_BACK;
          end else begin
            state_d = ST_ALLOCATE;
          end
        end
        ST_WRITE_BACK: begin
          pmem_write = 1'b1;
          write_back = 1'b1;
          if (pmem_resp) state_d = ST_ALLOCATE;
          else           state_d = ST_WRITE_BACK;
        end
        ST_ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            update     = 1'b1;
            load_tag   = way_onehot(victim_way_s);
            load_valid = way_onehot(victim_way_s);
            load_dirty = way_onehot(victim_way_s);
            valid_in   = 1'b1;
            state_d    = ST_REFETCH;
          end else begin
            state_d = ST_ALLOCATE;
          end
        end
        ST_REFETCH: begin
          read_arrays = 1'b1;
          state_d     = ST_TAG_CHECK;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] cnt_hit_q;
  logic [31:0] cnt_miss_q;
  logic [31:0] cnt_wb_q;
  logic        miss_evt_s;
  logic        wb_evt_s;

  assign miss_evt_s = (state_q == ST_TAG_CHECK) && req_s && (hit == 4'b0000);
  assign wb_evt_s   = (state_q == ST_WRITE_BACK) && pmem_resp;

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hit_q  <= 32'd0;
      cnt_miss_q <= 32'd0;
      cnt_wb_q   <= 32'd0;
    end else begin
      if (mem_resp)   cnt_hit_q  <= cnt_hit_q + 32'd1;
      if (miss_evt_s) cnt_miss_q <= cnt_miss_q + 32'd1;
      if (wb_evt_s)   cnt_wb_q   <= cnt_wb_q + 32'd1;
    end
  end

  assign cnt_hit  = cnt_hit_q;
  assign cnt_miss = cnt_miss_q;
  assign cnt_wb   = cnt_wb_q;
`else
  assign cnt_hit  = 32'd0;
  assign cnt_miss = 32'd0;
  assign cnt_wb   = 32'd0;
`endif

endmodule

// File: tb/tb_cache_control_4way.sv
// Scoreboard bench for cache_control_4way: each driven cycle queues its expected
// outputs; a negedge monitor pops and compares. Counter expectations follow CACHE_PERF_CNT_EN.
module tb_cache_control_4way;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  logic [3:0]  hit;
  logic        dirty_victim;
  logic [2:0]  lru_in;
  logic [2:0]  lru_out;
  logic        load_lru;
  logic        read_arrays;
  logic [3:0]  load_valid;
  logic [3:0]  load_tag;
  logic [3:0]  load_dirty;
  logic        valid_in;
  logic        dirty_in;
  logic        update;
  logic        write_back;
  logic        write_data;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;
  logic [31:0] cnt_hit;
  logic [31:0] cnt_miss;
  logic [31:0] cnt_wb;

`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [24:0] ctl;
    logic [31:0] h;
    logic [31:0] m;
    logic [31:0] w;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_x;
  logic [24:0] mon_act;
  int          vecs;
  int          errs;
  logic [31:0] m_hit;
  logic [31:0] m_miss;
  logic [31:0] m_wb;
  logic [24:0] z_v;
  logic [24:0] ra_v;
  logic [24:0] pr_v;
  logic [24:0] wb_v;

  cache_control_4way dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit(hit), .dirty_victim(dirty_victim), .lru_in(lru_in),
    .lru_out(lru_out), .load_lru(load_lru), .read_arrays(read_arrays),
    .load_valid(load_valid), .load_tag(load_tag), .load_dirty(load_dirty),
    .valid_in(valid_in), .dirty_in(dirty_in), .update(update),
    .write_back(write_back), .write_data(write_data), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .cnt_hit(cnt_hit),
    .cnt_miss(cnt_miss), .cnt_wb(cnt_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] pk(input logic resp, input logic [2:0] lo, input logic ll,
                                     input logic ra, input logic [3:0] lv, input logic [3:0] lt,
                                     input logic [3:0] ld, input logic vi, input logic di,
                                     input logic up, input logic wb, input logic wd,
                                     input logic pr, input logic pw);
    return {resp, lo, ll, ra, lv, lt, ld, vi, di, up, wb, wd, pr, pw};
  endfunction

  // inc = {hit, miss, wb} counter events caused by this cycle.
  task automatic step(input logic rd, input logic wr, input logic [3:0] h, input logic dv,
                      input logic [2:0] lru, input logic pr, input logic r,
                      input logic [24:0] e, input logic [2:0] inc);
    exp_t x;
    mem_read     = rd;
    mem_write    = wr;
    hit          = h;
    dirty_victim = dv;
    lru_in       = lru;
    pmem_resp    = pr;
    rst          = r;
    x.ctl = e;
    x.h   = PERF ? m_hit  : 32'd0;
    x.m   = PERF ? m_miss : 32'd0;
    x.w   = PERF ? m_wb   : 32'd0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (r) begin
      m_hit  = 32'd0;
      m_miss = 32'd0;
      m_wb   = 32'd0;
    end else begin
      m_hit  = m_hit  + {31'd0, inc[2]};
      m_miss = m_miss + {31'd0, inc[1]};
      m_wb   = m_wb   + {31'd0, inc[0]};
    end
  endtask

  // Monitor: every cycle is an output beat; compare against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        mon_x   = sb.pop_front();
        mon_act = {mem_resp, lru_out, load_lru, read_arrays, load_valid, load_tag, load_dirty,
                   valid_in, dirty_in, update, write_back, write_data, pmem_read, pmem_write};
        vecs = vecs + 1;
        if (mon_act !== mon_x.ctl || cnt_hit !== mon_x.h || cnt_miss !== mon_x.m ||
            cnt_wb !== mon_x.w) begin
          errs = errs + 1;
          $display("FAIL cyc%0d ctl got=%h want=%h cnt got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   vecs, mon_act, mon_x.ctl, cnt_hit, cnt_miss, cnt_wb,
                   mon_x.h, mon_x.m, mon_x.w);
        end
      end
    end
  end

  initial begin
    vecs = 0; errs = 0;
    m_hit = 32'd0; m_miss = 32'd0; m_wb = 32'd0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 4'b0000;
    dirty_victim = 1'b0; lru_in = 3'b000; pmem_resp = 1'b0;
    z_v  = 25'd0;
    ra_v = pk(1'b0, 3'b000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pr_v = pk(1'b0, 3'b000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wb_v = pk(1'b0, 3'b000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    // reset, then idle
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, z_v, 3'b000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // read hit way3, lru 000
    step(1'b1, 1'b0, 4'b0100, 1'b0, 3'b000, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b0100, 1'b0, 3'b000, 1'b0, 1'b0,
         pk(1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // read hit way2, lru 000
    step(1'b1, 1'b0, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b0,
         pk(1'b1, 3'b100, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // multi-bit hit 1110 resolves to way2, lru 011
    step(1'b1, 1'b0, 4'b1110, 1'b0, 3'b011, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b1110, 1'b0, 3'b011, 1'b0, 1'b0,
         pk(1'b1, 3'b101, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // write hit way4, lru 111
    step(1'b0, 1'b1, 4'b1000, 1'b0, 3'b111, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 3'b111, 1'b0, 1'b0,
         pk(1'b1, 3'b010, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // read+write together is a write; hit way1, lru 000
    step(1'b1, 1'b1, 4'b0001, 1'b0, 3'b000, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b1, 4'b0001, 1'b0, 3'b000, 1'b0, 1'b0,
         pk(1'b1, 3'b110, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // clean read miss, lru 101 -> victim way4, pmem_resp on 5th allocate cycle
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b101, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b101, 1'b0, 1'b0, z_v, 3'b010);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b101, 1'b0, 1'b0, pr_v, 3'b000);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b101, 1'b1, 1'b0,
         pk(1'b0, 3'b000, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 3'b000);
    step(1'b1, 1'b0, 4'b1000, 1'b0, 3'b101, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b1000, 1'b0, 3'b101, 1'b0, 1'b0,
         pk(1'b1, 3'b000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // dirty write miss, lru 010 -> victim way2
    step(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0, z_v, 3'b010);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0, wb_v, 3'b000);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0, wb_v, 3'b000);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b1, 1'b0, wb_v, 3'b001);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0, pr_v, 3'b000);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b1, 1'b0,
         pk(1'b0, 3'b000, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 3'b000);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 3'b010, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 3'b010, 1'b0, 1'b0,
         pk(1'b1, 3'b100, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // request dropped mid-miss: fill completes, no mem_resp
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b010);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, pr_v, 3'b000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b1, 1'b0,
         pk(1'b0, 3'b000, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 3'b000);
    step(1'b0, 1'b0, 4'b0001, 1'b0, 3'b000, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b0, 1'b0, 4'b0001, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    // reset during allocate, then a fresh hit proves the FSM is back in IDLE
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b010);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, pr_v, 3'b000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, z_v, 3'b000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    step(1'b1, 1'b0, 4'b0100, 1'b0, 3'b000, 1'b0, 1'b0, ra_v, 3'b000);
    step(1'b1, 1'b0, 4'b0100, 1'b0, 3'b000, 1'b0, 1'b0,
         pk(1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'b100);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, z_v, 3'b000);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errs = errs + 1;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
